fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch from the synchronous instruction memory, whose read latency is LOAD_LATENCY.
- Tracks in-flight fetches with valid bits, applies branch redirects, stalls and halts, and generates the pipeline flush.
- Sits between write-back (branch resolve, stall) and the fetch stage. It takes over PC advance, pending-PC queueing and flush timing from the write-back stage.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_inflight_queue.sv | 56 +++++
 rtl/fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer.
//   fseq_state_t : sequencer FSM state
//   addr_t       : default-width program counter
//   pcq_entry_t  : one in-flight fetch record {pc, valid}
package fetch_sequencer_pkg;

   localparam int FSEQ_ADDR_W = 32;
   localparam int PERF_CNT_W  = 32;

   typedef logic [FSEQ_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } fseq_state_t;

   typedef struct packed {
      addr_t pc;
      logic  v;
   } pcq_entry_t;

endpackage

// File: rtl/fetch_inflight_queue.sv
// In-flight fetch tracker: a DEPTH-stage shift register of {pc, v}.
// Ports:
//   clk, rstn        clock / async active-low reset
//   hold             freeze every entry (downstream stall)
//   inv_all          clear every valid bit at this edge; the shift still happens
//   in_pc, in_v      record entering stage 0
//   out_pc, out_v    oldest record (stage DEPTH-1)
module fetch_inflight_queue
   import fetch_sequencer_pkg::*;
#(
   parameter int DEPTH  = 1,
   parameter int ADDR_W = FSEQ_ADDR_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              hold,
   input  logic              inv_all,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic              in_v,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_v
);

   logic [DEPTH-1:0][ADDR_W-1:0] pc_q, pc_d;
   logic [DEPTH-1:0]             v_q, v_d;

   always_comb begin
      pc_d = pc_q;
      v_d  = v_q;
      if (!hold) begin
         pc_d[0] = in_pc;
         v_d[0]  = in_v;
         for (int i = 1; i < DEPTH; i++) begin
            pc_d[i] = pc_q[i-1];
            v_d[i]  = v_q[i-1];
         end
      end
      if (inv_all) begin
         v_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q <= '0;
         v_q  <= '0;
      end else begin
         pc_q <= pc_d;
         v_q  <= v_d;
      end
   end

   assign out_pc = pc_q[DEPTH-1];
   assign out_v  = v_q[DEPTH-1];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues fetches to a synchronous instruction
// memory of read latency LOAD_LATENCY, tracks in-flight fetches, and applies
// branch redirects, stalls, halts and the pipeline flush.
//
// Ports:
//   clk, rstn      clock / async active-low reset
//   be, bd         redirect strobe and target
//   stall_req      hold PC and in-flight queue
//   halt_req       enter HALT (stop issuing)
//   resume         leave HALT
//   pc_to_mem      current PC to instruction memory
//   fetch_issue    pc_to_mem is a real fetch this cycle
//   pc_to_fet      PC of the word returning this cycle
//   inst_valid     returning word is valid
//   flush          pipeline flush, LOAD_LATENCY cycles after a redirect
//   halted         state is HALT
//   redirect_cnt   (FETCH_PERF_CNT_EN only) saturating count of be cycles
//   stall_cnt      (FETCH_PERF_CNT_EN only) saturating count of stall cycles outside HALT
//
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
//
// state | meaning
// RUN   | issuing sequential fetches
// FLUSH | redirect taken, flush counter running, still issuing
// HALT  | no new fetches, PC held, in-flight words drain
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                LOAD_LATENCY = 1,
   parameter int                ADDR_W       = FSEQ_ADDR_W,
   parameter logic [ADDR_W-1:0] INIT_RIP     = '0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              be,
   input  logic [ADDR_W-1:0] bd,
   input  logic              stall_req,
   input  logic              halt_req,
   input  logic              resume,
   output logic [ADDR_W-1:0] pc_to_mem,
   output logic              fetch_issue,
   output logic [ADDR_W-1:0] pc_to_fet,
   output logic              inst_valid,
   output logic              flush,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] redirect_cnt,
   output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

   localparam int             CNT_W     = $clog2(LOAD_LATENCY + 1);
   localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(LOAD_LATENCY);

   fseq_state_t       state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              q_out_v;
   logic              q_hold;

   // Gated by rstn so no fetch is advertised while the block is held in reset.
   assign fetch_issue = rstn & (state_q != HALT) & ~stall_req & ~be;
   assign pc_to_mem   = pc_q;
   assign flush       = (flush_cnt_q != '0);
   assign halted      = (state_q == HALT);
   assign inst_valid  = q_out_v & ~flush;
   // A redirect overrides a simultaneous stall, so the queue still shifts.
   assign q_hold      = stall_req & ~be;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flush_cnt_d = (flush_cnt_q != '0) ? flush_cnt_q - CNT_W'(1) : '0;

      // The PC moves on whenever its value was actually consumed by a fetch,
      // so the held PC after a halt is the first address not yet fetched.
      if (be) begin
         pc_d        = bd;
         flush_cnt_d = FLUSH_LEN;
      end else if (fetch_issue) begin
         pc_d = pc_q + ADDR_W'(1);
      end

      case (state_q)
         RUN: begin
            if (be)            state_d = FLUSH;
            else if (halt_req) state_d = HALT;
         end
         FLUSH: begin
            if (be)                     state_d = FLUSH;
            else if (halt_req)          state_d = HALT;
            else if (flush_cnt_d == '0) state_d = RUN;
         end
         HALT: begin
            if (!be && resume && !halt_req) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= RUN;
         pc_q        <= INIT_RIP;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   fetch_inflight_queue #(
      .DEPTH  (LOAD_LATENCY),
      .ADDR_W (ADDR_W)
   ) u_queue (
      .clk     (clk),
      .rstn    (rstn),
      .hold    (q_hold),
      .inv_all (be),
      .in_pc   (pc_q),
      .in_v    (fetch_issue),
      .out_pc  (pc_to_fet),
      .out_v   (q_out_v)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      redirect_cnt_d = redirect_cnt_q;
      stall_cnt_d    = stall_cnt_q;
      if (be && (redirect_cnt_q != '1)) begin
         redirect_cnt_d = redirect_cnt_q + PERF_CNT_W'(1);
      end
      if (stall_req && (state_q != HALT) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         redirect_cnt_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign redirect_cnt = redirect_cnt_q;
   assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        be;
   logic [31:0] bd;
   logic        stall_req;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc_to_mem;
   logic        fetch_issue;
   logic [31:0] pc_to_fet;
   logic        inst_valid;
   logic        flush;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] redirect_cnt;
   logic [31:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;
   logic [31:0] exp_q[$];

   fetch_sequencer #(
      .LOAD_LATENCY (2),
      .ADDR_W       (32),
      .INIT_RIP     (32'h100)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .be          (be),
      .bd          (bd),
      .stall_req   (stall_req),
      .halt_req    (halt_req),
      .resume      (resume),
      .pc_to_mem   (pc_to_mem),
      .fetch_issue (fetch_issue),
      .pc_to_fet   (pc_to_fet),
      .inst_valid  (inst_valid),
      .flush       (flush),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .redirect_cnt (redirect_cnt),
      .stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a returning word is consumed when it is valid and downstream
   // is not stalled (a redirect overrides the stall).
   always @(negedge clk) begin
      if (mon_en && rstn && inst_valid && (!stall_req || be)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_unexpected: got %h expected none (t=%0t)", pc_to_fet, $time);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (pc_to_fet !== e) begin
               errors++;
               $display("FAIL stream_pc: got %h expected %h (t=%0t)", pc_to_fet, e, $time);
            end
         end
      end
   end

   initial begin
      logic [31:0] exp_list [0:20];
      exp_list = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104,
                   32'h40, 32'h41, 32'h42, 32'h43, 32'h44,
                   32'h200, 32'h201, 32'h202, 32'h203, 32'h204,
                   32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h0, 32'h0};

      rstn = 1'b0; be = 1'b0; bd = '0; stall_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
      @(negedge clk);
      chk ("rst_pc_to_mem", pc_to_mem, 32'h100);
      chk1("rst_fetch_issue", fetch_issue, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk ("rst_pc_to_fet", pc_to_fet, 32'h0);

      for (int i = 0; i < 19; i++) exp_q.push_back(exp_list[i]);
      mon_en = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b1;

      for (int c = 0; c <= 36; c++) begin
         be = 1'b0; bd = '0; stall_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
         case (c)
            6:          begin be = 1'b1; bd = 32'h40; end
            11, 12, 13: stall_req = 1'b1;
            16:         begin be = 1'b1; bd = 32'h80; end
            17:         begin be = 1'b1; bd = 32'h200; end
            21:         begin halt_req = 1'b1; stall_req = 1'b1; end
            26:         resume = 1'b1;
            30:         begin be = 1'b1; bd = 32'hFFFF_FFFF; end
            36:         begin be = 1'b1; bd = 32'h500; end
            default: ;
         endcase
         @(negedge clk);
         case (c)
            0:  begin chk("c0_pc", pc_to_mem, 32'h100); chk1("c0_issue", fetch_issue, 1'b1);
                      chk1("c0_ivalid", inst_valid, 1'b0); end
            1:  chk("c1_pc", pc_to_mem, 32'h101);
            2:  begin chk("c2_pc", pc_to_mem, 32'h102); chk("c2_fet", pc_to_fet, 32'h100);
                      chk1("c2_ivalid", inst_valid, 1'b1); end
            6:  chk1("be_no_issue", fetch_issue, 1'b0);
            7:  begin chk("be_pc", pc_to_mem, 32'h40); chk1("be_flush1", flush, 1'b1);
                      chk1("be_ivalid1", inst_valid, 1'b0); end
            8:  begin chk1("be_flush2", flush, 1'b1); chk1("be_ivalid2", inst_valid, 1'b0); end
            9:  begin chk1("be_flush_end", flush, 1'b0); chk("be_fet", pc_to_fet, 32'h40);
                      chk1("be_fet_valid", inst_valid, 1'b1); end
            11, 12, 13: begin chk("stall_pc", pc_to_mem, 32'h44);
                      chk1("stall_issue", fetch_issue, 1'b0); chk("stall_fet", pc_to_fet, 32'h42); end
            14: begin chk("unstall_pc", pc_to_mem, 32'h44); chk1("unstall_issue", fetch_issue, 1'b1); end
            15: chk("unstall_pc_next", pc_to_mem, 32'h45);
            17: begin chk("be2_pc", pc_to_mem, 32'h80); chk1("be2_issue", fetch_issue, 1'b0);
                      chk1("be2_flush1", flush, 1'b1); end
            18: begin chk("be2_pc2", pc_to_mem, 32'h200); chk1("be2_flush2", flush, 1'b1);
                      chk1("be2_ivalid2", inst_valid, 1'b0); end
            19: begin chk1("be2_flush3", flush, 1'b1); chk1("be2_ivalid3", inst_valid, 1'b0); end
            20: chk1("be2_flush_end", flush, 1'b0);
            22, 24, 25: begin chk1("halt_halted", halted, 1'b1);
                      chk1("halt_issue", fetch_issue, 1'b0); chk("halt_pc", pc_to_mem, 32'h203); end
            23: begin chk1("halt_halted", halted, 1'b1); chk("halt_drain_fet", pc_to_fet, 32'h202);
                      chk1("halt_drain_valid", inst_valid, 1'b1); end
            26: begin chk1("resume_still_halted", halted, 1'b1); chk1("resume_issue", fetch_issue, 1'b0); end
            27: begin chk1("run_halted", halted, 1'b0); chk1("run_issue", fetch_issue, 1'b1);
                      chk("run_pc", pc_to_mem, 32'h203); end
            31: chk("wrap_pc_max", pc_to_mem, 32'hFFFF_FFFF);
            32: chk("wrap_pc_zero", pc_to_mem, 32'h0);
            33: begin chk("wrap_fet", pc_to_fet, 32'hFFFF_FFFF); chk1("wrap_valid", inst_valid, 1'b1); end
            default: ;
         endcase
         @(posedge clk); #1;
      end

      // Cycle 37: flush running from the last redirect; reset lands mid-flush.
      be = 1'b0; bd = '0;
      chk1("mid_flush", flush, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirects", redirect_cnt, 32'd5);
      chk("perf_stalls", stall_cnt, 32'd4);
`endif
      #2 rstn = 1'b0;
      #1;
      chk1("arst_flush", flush, 1'b0);
      chk1("arst_ivalid", inst_valid, 1'b0);
      chk1("arst_issue", fetch_issue, 1'b0);
      chk ("arst_pc", pc_to_mem, 32'h100);
      chk ("arst_fet", pc_to_fet, 32'h0);
      chk1("arst_halted", halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      chk("arst_redirect_cnt", redirect_cnt, 32'd0);
`endif
      @(negedge clk);
      chk("stream_drained", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;

      @(posedge clk); #1;
      rstn = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         be = (c == 1) || (c == 3);
         bd = 32'h10;
         @(negedge clk);
         if (c == 0) chk1("post_rst_no_stale", inst_valid, 1'b0);
         @(posedge clk); #1;
      end
      be = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      chk("perf_two_redirects", redirect_cnt, 32'd2);
      chk("perf_no_stalls", stall_cnt, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
